// File: rtl/ysyx_22041211_mem_arbiter.sv
// Memory-port arbiter: shares one pmem request/response port between IFU and LSU.
// Ports: clk/rst, if_* (fetch read), ls_* (load/store), mem_* (pmem bridge), stray_rsp_o.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN      = 32,
    parameter int DATA_LEN      = 32,
    parameter int LS_STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_LEN-1:0]   if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_LEN-1:0]   if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_wen_i,
    input  logic [ADDR_LEN-1:0]   ls_addr_i,
    input  logic [DATA_LEN-1:0]   ls_wdata_i,
    input  logic [DATA_LEN/8-1:0] ls_wmask_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_LEN-1:0]   ls_rdata_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_LEN-1:0]   mem_addr_o,
    output logic                  mem_wen_o,
    output logic [DATA_LEN-1:0]   mem_wdata_o,
    output logic [DATA_LEN/8-1:0] mem_wmask_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_LEN-1:0]   mem_rdata_i,
    output logic                  stray_rsp_o
);

    localparam int SW = $clog2(LS_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_SAT = SW'(LS_STREAK_MAX);

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_LS,
        WAIT_IF,
        WAIT_LS
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          pick_if, pick_ls;

    // Winner selection; only meaningful in IDLE. Gated by rst so
    // nothing is granted while reset is held.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (state == IDLE && !rst) begin
            if (if_req_i && (!ls_req_i || streak == STREAK_SAT)) begin
                pick_if = 1'b1;
            end else if (ls_req_i) begin
                pick_ls = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        if_gnt_o    = pick_if;
        ls_gnt_o    = pick_ls;
        mem_valid_o = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        stray_rsp_o = 1'b0;
        unique case (state)
            IDLE: begin
                stray_rsp_o = mem_rvalid_i && !rst;
                if (pick_if) begin
                    state_nxt  = REQ_IF;
                    streak_nxt = '0;
                end else if (pick_ls) begin
                    state_nxt = REQ_LS;
                    // Streak only grows while the IFU is actually waiting.
                    if (!if_req_i) begin
                        streak_nxt = '0;
                    end else if (streak != STREAK_SAT) begin
                        streak_nxt = streak + SW'(1);
                    end
                end
            end
            REQ_IF, REQ_LS: begin
                mem_valid_o = 1'b1;
                stray_rsp_o = mem_rvalid_i;
                if (mem_ready_i) begin
                    state_nxt = (state == REQ_IF) ? WAIT_IF : WAIT_LS;
                end
            end
            WAIT_IF: begin
                if_rvalid_o = mem_rvalid_i;
                if (mem_rvalid_i) state_nxt = IDLE;
            end
            WAIT_LS: begin
                ls_rvalid_o = mem_rvalid_i;
                if (mem_rvalid_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign if_rdata_o = mem_rdata_i;
    assign ls_rdata_o = mem_rdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            mem_addr_o  <= '0;
            mem_wen_o   <= 1'b0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            if (pick_if) begin
                mem_addr_o  <= if_addr_i;
                mem_wen_o   <= 1'b0;
                mem_wdata_o <= '0;
                mem_wmask_o <= '1;
            end else if (pick_ls) begin
                mem_addr_o  <= ls_addr_i;
                mem_wen_o   <= ls_wen_i;
                mem_wdata_o <= ls_wdata_i;
                mem_wmask_o <= ls_wmask_i;
            end
        end
    end

endmodule
